// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline definitions: frame geometry, census vector width and
// the correlation scheduler state encoding.
package stereo_pkg;

  localparam int F_WIDTH  = 320;
  localparam int F_HEIGHT = 240;
  localparam int BITVEC_W = 72;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/correlate_scheduler_raster_counter.sv
// Raster-order pixel coordinate counter; wraps x per line and y per frame and
// flags the final pixel of the frame.
module raster_counter #(
  parameter int F_WIDTH  = stereo_pkg::F_WIDTH,
  parameter int F_HEIGHT = stereo_pkg::F_HEIGHT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           advance,
  output logic [stereo_pkg::COORD_W-1:0] x,
  output logic [stereo_pkg::COORD_W-1:0] y,
  output logic                           last
);
  import stereo_pkg::*;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(F_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(F_HEIGHT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/correlate_scheduler.sv
// Pairs left/right census vectors, rate-limits and credit-limits their issue to
// the correlator, stamps raster coordinates and reports frame completion.
module correlate_scheduler #(
  parameter int F_WIDTH      = stereo_pkg::F_WIDTH,
  parameter int F_HEIGHT     = stereo_pkg::F_HEIGHT,
  parameter int BITVEC_W     = stereo_pkg::BITVEC_W,
  parameter int ISSUE_GAP    = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [BITVEC_W-1:0]            left_bitvec,
  input  logic                           left_valid,
  output logic                           left_ready,
  input  logic [BITVEC_W-1:0]            right_bitvec,
  input  logic                           right_valid,
  output logic                           right_ready,
  output logic [BITVEC_W-1:0]            corr_left_bitvec,
  output logic [BITVEC_W-1:0]            corr_right_bitvec,
  output logic                           corr_bitvec_val,
  output logic [stereo_pkg::COORD_W-1:0] corr_input_x,
  output logic [stereo_pkg::COORD_W-1:0] corr_input_y,
  input  logic                           disparity_val,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           credit_err
);
  import stereo_pkg::*;

  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  sched_state_t       state, next_state;
  logic               issue, start_frame;
  logic [INF_W-1:0]   inflight;
  logic [GAP_W-1:0]   gap_cnt;
  logic [COORD_W-1:0] x_p0, y_p0;
  logic               last_p0;

  logic                vld_p1;
  logic [BITVEC_W-1:0] left_p1, right_p1;
  logic [COORD_W-1:0]  x_p1, y_p1;

  raster_counter #(
    .F_WIDTH (F_WIDTH),
    .F_HEIGHT(F_HEIGHT)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_frame),
    .advance(issue),
    .x      (x_p0),
    .y      (y_p0),
    .last   (last_p0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)               next_state = RUN;
      RUN:     if (issue && last_p0)    next_state = DRAIN;
      DRAIN:   if (inflight == '0)      next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  always_comb begin
    start_frame = (state == IDLE) && start;
    issue       = (state == RUN) && left_valid && right_valid &&
                  (gap_cnt == '0) && (inflight < INF_W'(MAX_INFLIGHT));
    left_ready  = issue;
    right_ready = issue;
    busy        = (state != IDLE);
    frame_done  = (state == DRAIN) && (inflight == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (start_frame) begin
      gap_cnt <= '0;
    end else if (issue) begin
      gap_cnt <= GAP_W'(ISSUE_GAP - 1);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // A return with nothing outstanding is flagged, never allowed to underflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight   <= '0;
      credit_err <= 1'b0;
    end else begin
      case ({issue, disparity_val})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01: begin
          if (inflight == '0) credit_err <= 1'b1;
          else                inflight   <= inflight - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // p0 -> p1: registered issue toward the correlator; data holds between issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      left_p1  <= '0;
      right_p1 <= '0;
      x_p1     <= '0;
      y_p1     <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        left_p1  <= left_bitvec;
        right_p1 <= right_bitvec;
        x_p1     <= x_p0;
        y_p1     <= y_p0;
      end
    end
  end

  assign corr_bitvec_val   = vld_p1;
  assign corr_left_bitvec  = left_p1;
  assign corr_right_bitvec = right_p1;
  assign corr_input_x      = x_p1;
  assign corr_input_y      = y_p1;

endmodule

// File: tb/tb_correlate_scheduler.sv
// Bench for correlate_scheduler: a scoreboarded 4x2 frame instance and a
// credit-limited instance driven from a cycle table.
module tb_correlate_scheduler;

  localparam int W = 4;
  localparam int H = 2;
  localparam logic [71:0] B_L = 72'h11_2233_4455_6677_8899;
  localparam logic [71:0] B_R = 72'hEE_DDCC_BBAA_9988_7766;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: MAX_INFLIGHT=8, ISSUE_GAP=2
  logic        a_start, a_lv, a_rv, a_lr, a_rr, a_cv, a_disp, a_busy, a_fd, a_cerr;
  logic        man_disp;
  logic [71:0] a_lvec, a_rvec, a_cl, a_cr;
  logic [9:0]  a_cx, a_cy;
  int          idx = 0;

  // instance B: MAX_INFLIGHT=2, ISSUE_GAP=1
  logic        b_start, b_v, b_lr, b_rr, b_cv, b_disp, b_busy, b_fd, b_cerr;
  logic [71:0] b_lvec, b_rvec, b_cl, b_cr;
  logic [9:0]  b_cx, b_cy;

  function automatic logic [71:0] mkvec(input bit side, input int k);
    return {(side ? 8'hB5 : 8'h3C), 32'(k), 32'(k * 7 + 3)};
  endfunction

  assign a_lvec = mkvec(1'b0, idx);
  assign a_rvec = mkvec(1'b1, idx);
  assign b_lvec = B_L;
  assign b_rvec = B_R;

  correlate_scheduler #(
    .F_WIDTH(W), .F_HEIGHT(H), .BITVEC_W(72), .ISSUE_GAP(2), .MAX_INFLIGHT(8)
  ) dut_a (
    .clk(clk), .reset(rst_n), .start(a_start),
    .left_bitvec(a_lvec), .left_valid(a_lv), .left_ready(a_lr),
    .right_bitvec(a_rvec), .right_valid(a_rv), .right_ready(a_rr),
    .corr_left_bitvec(a_cl), .corr_right_bitvec(a_cr), .corr_bitvec_val(a_cv),
    .corr_input_x(a_cx), .corr_input_y(a_cy), .disparity_val(a_disp),
    .busy(a_busy), .frame_done(a_fd), .credit_err(a_cerr)
  );

  correlate_scheduler #(
    .F_WIDTH(W), .F_HEIGHT(H), .BITVEC_W(72), .ISSUE_GAP(1), .MAX_INFLIGHT(2)
  ) dut_b (
    .clk(clk), .reset(rst_n), .start(b_start),
    .left_bitvec(b_lvec), .left_valid(b_v), .left_ready(b_lr),
    .right_bitvec(b_rvec), .right_valid(b_v), .right_ready(b_rr),
    .corr_left_bitvec(b_cl), .corr_right_bitvec(b_cr), .corr_bitvec_val(b_cv),
    .corr_input_x(b_cx), .corr_input_y(b_cy), .disparity_val(b_disp),
    .busy(b_busy), .frame_done(b_fd), .credit_err(b_cerr)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // correlator model: one disparity return 3 cycles after each issue pulse
  logic [2:0] echo_sr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) echo_sr <= '0;
    else        echo_sr <= {echo_sr[1:0], a_cv};
  end
  assign a_disp = echo_sr[2] | man_disp;

  // scoreboard: push on handshake, pop on corr_bitvec_val
  typedef struct {
    logic [71:0] l;
    logic [71:0] r;
    logic [9:0]  x;
    logic [9:0]  y;
  } sb_t;
  sb_t sb_q[$];
  int  exp_x = 0, exp_y = 0;
  int  n_pulse = 0, first_pulse = 0, last_pulse = 0;
  int  fd_cnt = 0, fd_cyc = 0;
  bit  pop_pend = 1'b0;

  always @(negedge clk) begin
    sb_t e;
    if (a_cv) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_issue: got corr_bitvec_val=1, expected no pending issue");
      end else begin
        e = sb_q.pop_front();
        chk("sb_left_vec", a_cl, e.l);
        chk("sb_right_vec", a_cr, e.r);
        chk("sb_x", a_cx, e.x);
        chk("sb_y", a_cy, e.y);
      end
      if (n_pulse == 0) first_pulse = cyc;
      else              chk("issue_gap", cyc - last_pulse, 2);
      last_pulse = cyc;
      n_pulse++;
    end
    if (a_lr || a_rr) begin
      chk("ready_pair", {a_lr, a_rr}, 2'b11);
      e.l = a_lvec;
      e.r = a_rvec;
      e.x = 10'(exp_x);
      e.y = 10'(exp_y);
      sb_q.push_back(e);
      if (exp_x == W - 1) begin
        exp_x = 0;
        exp_y = (exp_y == H - 1) ? 0 : exp_y + 1;
      end else begin
        exp_x++;
      end
      pop_pend = 1'b1;
    end
    if (a_fd) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      idx++;
      pop_pend = 1'b0;
    end
  end

  task automatic run_frame(input string tag, input bit mid_start, input int skew);
    int s, fd0;
    bit done, m1, m2;
    done = 1'b0; m1 = 1'b0; m2 = 1'b0;
    fd0 = fd_cnt; n_pulse = 0; exp_x = 0; exp_y = 0;
    if (skew > 0) a_rv = 1'b0;
    a_start = 1'b1;
    s = cyc;
    step();
    a_start = 1'b0;
    for (int i = 0; i < skew; i++) begin
      chk({tag, "_skew_lready"}, a_lr, 1'b0);
      chk({tag, "_skew_rready"}, a_rr, 1'b0);
      chk({tag, "_skew_val"}, a_cv, 1'b0);
      step();
    end
    a_rv = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      a_start = 1'b0;
      if (mid_start && n_pulse == 3 && !m1) begin
        chk({tag, "_busy_run"}, a_busy, 1'b1);
        a_start = 1'b1;
        m1 = 1'b1;
      end
      if (mid_start && n_pulse == 8 && !m2) begin
        chk({tag, "_busy_drain"}, a_busy, 1'b1);
        a_start = 1'b1;
        m2 = 1'b1;
      end
      step();
      if (fd_cnt != fd0) done = 1'b1;
    end
    a_start = 1'b0;
    chk({tag, "_frame_done_seen"}, done, 1'b1);
    chk({tag, "_busy_after_done"}, a_busy, 1'b0);
    chk({tag, "_pulse_count"}, n_pulse, 8);
    chk({tag, "_first_pulse_lat"}, first_pulse - s, skew + 2);
    if (done) chk({tag, "_done_lat"}, fd_cyc - last_pulse, 4);
    repeat (3) step();
    chk({tag, "_single_done"}, fd_cnt, fd0 + 1);
    chk({tag, "_idle_busy"}, a_busy, 1'b0);
  endtask

  typedef struct {
    logic       disp;
    logic       ready;
    logic       val;
    logic [9:0] x;
  } row_t;
  row_t tbl[9];

  initial begin
    bit found;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 10'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 10'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 10'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 10'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 10'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 10'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 10'd2};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 10'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 10'd0};

    rst_n = 1'b0;
    a_start = 1'b0; a_lv = 1'b1; a_rv = 1'b1; man_disp = 1'b0;
    b_start = 1'b0; b_v = 1'b1; b_disp = 1'b0;
    repeat (3) step();
    chk("rst_val", a_cv, 1'b0);
    chk("rst_lready", a_lr, 1'b0);
    chk("rst_rready", a_rr, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_fd, 1'b0);
    chk("rst_cerr", a_cerr, 1'b0);
    chk("rst_x", a_cx, 10'd0);
    chk("rst_y", a_cy, 10'd0);
    chk("rst_lvec", a_cl, 72'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // credit-limited instance, cycle by cycle after its start
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b_disp = tbl[i].disp;
      #1;
      chk($sformatf("tbl%0d_lready", i), b_lr, tbl[i].ready);
      chk($sformatf("tbl%0d_rready", i), b_rr, tbl[i].ready);
      chk($sformatf("tbl%0d_val", i), b_cv, tbl[i].val);
      if (tbl[i].val) begin
        chk($sformatf("tbl%0d_x", i), b_cx, tbl[i].x);
        chk($sformatf("tbl%0d_y", i), b_cy, 10'd0);
        chk($sformatf("tbl%0d_lvec", i), b_cl, B_L);
        chk($sformatf("tbl%0d_rvec", i), b_cr, B_R);
      end
      step();
    end
    b_disp = 1'b0;
    chk("b_busy", b_busy, 1'b1);
    chk("b_cerr", b_cerr, 1'b0);
    chk("b_done", b_fd, 1'b0);

    // stray return in IDLE
    chk("idle_cerr_before", a_cerr, 1'b0);
    man_disp = 1'b1;
    step();
    man_disp = 1'b0;
    chk("idle_cerr_set", a_cerr, 1'b1);
    chk("idle_busy", a_busy, 1'b0);

    run_frame("f1", 1'b0, 0);
    chk("f1_cerr_sticky", a_cerr, 1'b1);
    run_frame("f2_midstart", 1'b1, 0);
    run_frame("f3_skew", 1'b0, 5);

    // async reset while pixel (2,1) is being presented
    n_pulse = 0; exp_x = 0; exp_y = 0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (a_cv && a_cx == 10'd2 && a_cy == 10'd1) found = 1'b1;
    end
    chk("mid_reach_2_1", found, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_val", a_cv, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_lready", a_lr, 1'b0);
    chk("mid_rst_rready", a_rr, 1'b0);
    sb_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_cerr", a_cerr, 1'b0);
    chk("post_rst_busy", a_busy, 1'b0);
    run_frame("f4_after_rst", 1'b0, 0);
    chk("f4_cerr", a_cerr, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
